// File: rtl/rans_enc_interleaved.sv
// Interleaved byte-wise rANS encoder: NUM_LANES coder states fed round-robin, in-band frequency table.
// Optional RANS_FREQ_CHECK_EN: table writes with freq==0 or cum+freq > 2^RESOLUTION are rejected.
module rans_enc_interleaved #(
  parameter int unsigned RESOLUTION   = 10,
  parameter int unsigned SYMBOL_WIDTH = 8,
  parameter int unsigned STATE_WIDTH  = 32,
  parameter int unsigned NUM_LANES    = 2,
  localparam int unsigned LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      valid_i,
  input  logic                      freq_wr_i,
  input  logic                      restart_i,
  input  logic [RESOLUTION-1:0]     freq_i,
  input  logic [RESOLUTION-1:0]     cum_freq_i,
  input  logic [SYMBOL_WIDTH-1:0]   symb_i,
  output logic                      ready_o,
  input  logic                      ready_i,
  output logic [1:0]                valid_o,
  output logic [2*SYMBOL_WIDTH-1:0] enc_o,
  output logic [LW-1:0]             lane_o,
  output logic                      last_o,
  output logic                      err_o
);

  localparam int unsigned BW2   = 2 * SYMBOL_WIDTH;
  localparam int unsigned BEATS = STATE_WIDTH / BW2;
  localparam int unsigned BTW   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned CW    = $clog2(STATE_WIDTH);
  localparam int unsigned TAB   = 2 ** SYMBOL_WIDTH;
  localparam int unsigned RW1   = RESOLUTION + 1;
  localparam logic [STATE_WIDTH-1:0] L_INIT = STATE_WIDTH'(1) << (STATE_WIDTH - SYMBOL_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, LOOKUP, RENORM, EMIT, DIVIDE, UPDATE, FLUSH} state_t;

  state_t                  state;
  logic [STATE_WIDTH-1:0]  lanes [NUM_LANES];
  logic [LW-1:0]           ptr;
  logic [STATE_WIDTH-1:0]  x_r;
  logic [RESOLUTION-1:0]   rem;
  logic [CW-1:0]           cnt;
  logic [LW-1:0]           fl_lane;
  logic [BTW-1:0]          fl_beat;

  logic [RESOLUTION-1:0]   freq_tab [TAB];
  logic [RESOLUTION-1:0]   cum_tab  [TAB];
  logic [RESOLUTION-1:0]   f_r, c_r;

  logic wr_ok, tab_wr, wr_bad, flush_go, accept;

`ifdef RANS_FREQ_CHECK_EN
  localparam logic [RESOLUTION:0] M_VAL = RW1'(1) << RESOLUTION;
  logic [RESOLUTION:0] wr_sum;
  assign wr_sum = {1'b0, cum_freq_i} + {1'b0, freq_i};
  assign wr_ok  = (freq_i != '0) && (wr_sum <= M_VAL);
`else
  assign wr_ok = 1'b1;
`endif

  // ready_o is high exactly in IDLE, so it doubles as the command gate
  assign tab_wr   = freq_wr_i && ready_o && wr_ok;
  assign wr_bad   = freq_wr_i && ready_o && !wr_ok;
  assign flush_go = restart_i && !freq_wr_i && ready_o;
  assign accept   = valid_i && ready_o && !freq_wr_i && !restart_i;

  // Table storage is deliberately not reset; read data is registered on accept
  always_ff @(posedge clk_i) begin
    if (tab_wr) begin
      freq_tab[symb_i] <= freq_i;
      cum_tab[symb_i]  <= cum_freq_i;
    end
    if (accept) begin
      f_r <= freq_tab[symb_i];
      c_r <= cum_tab[symb_i];
    end
  end

  logic [STATE_WIDTH-1:0] x_max, x1, x_new;
  logic                   sh1, sh2;
  logic [RESOLUTION:0]    rem_sh, f_ext;
  logic                   q_bit;
  logic [RESOLUTION-1:0]  rem_nx;
  logic [LW-1:0]          ptr_nx, nl;
  logic [BTW-1:0]         nb;
  logic                   fl_final, nx_last;
  logic [BW2-1:0]         nx_data;

  always_comb begin
    x_max    = STATE_WIDTH'(f_r) << (STATE_WIDTH - RESOLUTION - 1);
    x1       = x_r >> SYMBOL_WIDTH;
    sh1      = (x_r >= x_max);
    sh2      = sh1 && (x1 >= x_max);
    rem_sh   = {rem, x_r[STATE_WIDTH-1]};
    f_ext    = {1'b0, f_r};
    q_bit    = (rem_sh >= f_ext);
    rem_nx   = q_bit ? RESOLUTION'(rem_sh - f_ext) : rem_sh[RESOLUTION-1:0];
    x_new    = (x_r << RESOLUTION) + STATE_WIDTH'(rem) + STATE_WIDTH'(c_r);
    ptr_nx   = (ptr == LW'(NUM_LANES - 1)) ? '0 : ptr + LW'(1);
    nl       = fl_lane;
    nb       = fl_beat + BTW'(1);
    if (fl_beat == BTW'(BEATS - 1)) begin
      nl = fl_lane + LW'(1);
      nb = '0;
    end
    fl_final = (fl_lane == LW'(NUM_LANES - 1)) && (fl_beat == BTW'(BEATS - 1));
    nx_last  = (nl == LW'(NUM_LANES - 1)) && (nb == BTW'(BEATS - 1));
    nx_data  = BW2'(lanes[nl] >> (BW2 * nb));
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= IDLE;
      lanes   <= '{default: L_INIT};
      ptr     <= '0;
      x_r     <= '0;
      rem     <= '0;
      cnt     <= '0;
      fl_lane <= '0;
      fl_beat <= '0;
      ready_o <= 1'b1;
      valid_o <= 2'b00;
      enc_o   <= '0;
      lane_o  <= '0;
      last_o  <= 1'b0;
      err_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (wr_bad) err_o <= 1'b1;
          if (flush_go) begin
            state   <= FLUSH;
            ready_o <= 1'b0;
            fl_lane <= '0;
            fl_beat <= '0;
            enc_o   <= lanes[0][BW2-1:0];
            valid_o <= 2'b11;
            lane_o  <= '0;
            last_o  <= (NUM_LANES == 1) && (BEATS == 1);
          end else if (accept) begin
            state   <= LOOKUP;
            ready_o <= 1'b0;
          end
        end
        LOOKUP: begin
          if (f_r == '0) begin
            err_o   <= 1'b1;
            state   <= IDLE;
            ready_o <= 1'b1;
          end else begin
            x_r   <= lanes[ptr];
            state <= RENORM;
          end
        end
        // At most two bytes leave the state; the first one lands in the low half of enc_o
        RENORM: begin
          rem <= '0;
          cnt <= '0;
          if (sh2) begin
            x_r     <= x_r >> BW2;
            enc_o   <= x_r[BW2-1:0];
            valid_o <= 2'b11;
            lane_o  <= ptr;
            state   <= EMIT;
          end else if (sh1) begin
            x_r     <= x1;
            enc_o   <= BW2'(x_r[SYMBOL_WIDTH-1:0]);
            valid_o <= 2'b01;
            lane_o  <= ptr;
            state   <= EMIT;
          end else begin
            state <= DIVIDE;
          end
        end
        EMIT: begin
          if (ready_i) begin
            valid_o <= 2'b00;
            state   <= DIVIDE;
          end
        end
        // Restoring division: x_r shifts out dividend bits and collects quotient bits
        DIVIDE: begin
          x_r <= {x_r[STATE_WIDTH-2:0], q_bit};
          rem <= rem_nx;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(STATE_WIDTH - 1)) state <= UPDATE;
        end
        UPDATE: begin
          lanes[ptr] <= x_new;
          ptr        <= ptr_nx;
          state      <= IDLE;
          ready_o    <= 1'b1;
        end
        FLUSH: begin
          if (ready_i) begin
            if (fl_final) begin
              valid_o <= 2'b00;
              last_o  <= 1'b0;
              lanes   <= '{default: L_INIT};
              ptr     <= '0;
              state   <= IDLE;
              ready_o <= 1'b1;
            end else begin
              fl_lane <= nl;
              fl_beat <= nb;
              enc_o   <= nx_data;
              lane_o  <= nl;
              last_o  <= nx_last;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
